// File: rtl/edge_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel edge debounce detector.
package edge_debounce_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // Counter must hold DEBOUNCE_CYCLES-1 and never collapse to zero width.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/edge_debounce_if.sv
// Bundle of channel inputs and detector outputs between pads and register/irq logic.
interface edge_debounce_if #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic n_rst
);
    import edge_debounce_pkg::*;

    logic [WIDTH-1:0]   signal;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clr;
    logic [WIDTH-1:0]   filtered;
    logic [WIDTH-1:0]   pos_edge;
    logic [WIDTH-1:0]   neg_edge;
    logic [WIDTH-1:0]   pending;
    logic               irq;

    modport tester (
        input  clk, n_rst,
        output signal, mode, clr,
        input  filtered, pos_edge, neg_edge, pending, irq
    );

    modport dut (
        input  clk, n_rst,
        input  signal, mode, clr,
        output filtered, pos_edge, neg_edge, pending, irq
    );

endinterface

// File: rtl/edge_debounce_chan.sv
// One channel: synchroniser, debounce counter, filtered level, edge pulses and sticky pending flag.
module edge_debounce_chan
    import edge_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_signal,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_filtered,
    output logic       o_pos_edge,
    output logic       o_neg_edge,
    output logic       o_pending
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filtered;
    logic                   r_pos_edge;
    logic                   r_neg_edge;
    logic                   r_pending;

    edge_mode_t w_mode;
    logic       w_sync_q;
    logic       w_differs;
    logic       w_accept;
    logic       w_rise;
    logic       w_fall;
    logic       w_set;

    assign w_mode    = edge_mode_t'(i_mode);
    assign w_sync_q  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sync_q != r_filtered);
    assign w_accept  = w_differs && (r_cnt == CNT_MAX);
    assign w_rise    = w_accept && w_sync_q;
    assign w_fall    = w_accept && !w_sync_q;
    assign w_set     = (w_rise && (w_mode == EDGE_RISE || w_mode == EDGE_BOTH))
                    || (w_fall && (w_mode == EDGE_FALL || w_mode == EDGE_BOTH));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_filtered <= 1'b0;
            r_pos_edge <= 1'b0;
            r_neg_edge <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};

            // Any return to the filtered level, or an acceptance, restarts the count.
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_filtered <= w_sync_q;
            end

            r_pos_edge <= w_rise;
            r_neg_edge <= w_fall;

            // A new edge outranks a clear sampled on the same cycle.
            if (w_set) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_filtered = r_filtered;
    assign o_pos_edge = r_pos_edge;
    assign o_neg_edge = r_neg_edge;
    assign o_pending  = r_pending;

endmodule

// File: rtl/edge_debounce_detector.sv
// WIDTH independent debounced edge-detect channels with one aggregated interrupt.
module edge_debounce_detector
    import edge_debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    edge_debounce_if.dut bus
);

    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] w_pos_edge;
    logic [WIDTH-1:0] w_neg_edge;
    logic [WIDTH-1:0] w_pending;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .n_rst      (n_rst),
            .i_signal   (bus.signal[i]),
            .i_mode     (bus.mode[2*i +: 2]),
            .i_clr      (bus.clr[i]),
            .o_filtered (w_filtered[i]),
            .o_pos_edge (w_pos_edge[i]),
            .o_neg_edge (w_neg_edge[i]),
            .o_pending  (w_pending[i])
        );
    end

    assign bus.filtered = w_filtered;
    assign bus.pos_edge = w_pos_edge;
    assign bus.neg_edge = w_neg_edge;
    assign bus.pending  = w_pending;
    assign bus.irq      = |w_pending;

endmodule

// File: tb/tb_edge_debounce_detector.sv
// Scoreboard bench: stimulus queues expected edge events, a negedge monitor checks them.
module tb_edge_debounce_detector;

    localparam int W   = 8;
    localparam int LAT = 6;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic [7:0] neg;
        logic [7:0] filt;
        logic [7:0] pend;
    } ev_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    ev_t  q[$];

    edge_debounce_if #(.WIDTH(W)) bus (.clk(clk), .n_rst(n_rst));

    edge_debounce_detector #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_ev(input int at, input logic [7:0] pos, input logic [7:0] neg,
                             input logic [7:0] filt, input logic [7:0] pend);
        ev_t e;
        e.cyc  = at;
        e.pos  = pos;
        e.neg  = neg;
        e.filt = filt;
        e.pend = pend;
        q.push_back(e);
    endtask

    task automatic chk_state(input string name, input logic [7:0] filt, input logic [7:0] pend);
        chk({name, "_filtered"}, 32'(bus.filtered), 32'(filt));
        chk({name, "_pending"},  32'(bus.pending),  32'(pend));
        chk({name, "_irq"},      32'(bus.irq),      32'(|pend));
    endtask

    // Monitor: every edge pulse must match the next queued event, including its cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst && ((bus.pos_edge | bus.neg_edge) != '0)) begin
                if (q.size() == 0) begin
                    chk("unexpected_edge", 32'({bus.pos_edge, bus.neg_edge}), 32'h0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("ev_cycle",    32'(cyc),          32'(e.cyc));
                    chk("ev_pos_edge", 32'(bus.pos_edge), 32'(e.pos));
                    chk("ev_neg_edge", 32'(bus.neg_edge), 32'(e.neg));
                    chk("ev_filtered", 32'(bus.filtered), 32'(e.filt));
                    chk("ev_pending",  32'(bus.pending),  32'(e.pend));
                    chk("ev_irq",      32'(bus.irq),      32'(|e.pend));
                end
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        n_rst      = 1'b0;
        bus.signal = '0;
        bus.mode   = '0;
        bus.clr    = '0;

        // Reset and idle
        tick(3);
        chk_state("in_reset", 8'h00, 8'h00);
        n_rst = 1'b1;
        tick(20);
        chk_state("idle", 8'h00, 8'h00);

        // Clean rise on channel 0, mode rising, then clear
        bus.mode = 16'h0001;
        bus.signal[0] = 1'b1;
        expect_ev(cyc + LAT, 8'h01, 8'h00, 8'h01, 8'h01);
        tick(8);
        chk_state("rise_hold", 8'h01, 8'h01);
        bus.clr[0] = 1'b1;
        tick(1);
        bus.clr[0] = 1'b0;
        chk_state("after_clr", 8'h01, 8'h00);
        bus.signal[0] = 1'b0;
        expect_ev(cyc + LAT, 8'h00, 8'h01, 8'h00, 8'h00);
        tick(8);

        // Glitch rejection on channel 3: 3 cycles ignored, 5 cycles accepted
        bus.mode = '0;
        bus.signal[3] = 1'b1;
        tick(3);
        bus.signal[3] = 1'b0;
        tick(10);
        chk_state("glitch", 8'h00, 8'h00);
        bus.signal[3] = 1'b1;
        expect_ev(cyc + LAT,     8'h08, 8'h00, 8'h08, 8'h00);
        expect_ev(cyc + 5 + LAT, 8'h00, 8'h08, 8'h00, 8'h00);
        tick(5);
        bus.signal[3] = 1'b0;
        tick(10);

        // Mode matrix: ch0 none, ch1 rise, ch2 fall, ch3 both
        bus.mode = 16'h00E4;
        bus.signal[3:0] = 4'hF;
        expect_ev(cyc + LAT, 8'h0F, 8'h00, 8'h0F, 8'h0A);
        tick(10);
        bus.signal[3:0] = 4'h0;
        expect_ev(cyc + LAT, 8'h00, 8'h0F, 8'h00, 8'h0E);
        tick(10);
        chk_state("matrix_end", 8'h00, 8'h0E);
        bus.clr = 8'h0F;
        tick(1);
        bus.clr = '0;
        chk_state("matrix_clr", 8'h00, 8'h00);

        // Set/clear collision: clr held on mode-both channel 1
        bus.mode = 16'h000C;
        bus.clr[1] = 1'b1;
        bus.signal[1] = 1'b1;
        expect_ev(cyc + LAT, 8'h02, 8'h00, 8'h02, 8'h02);
        tick(7);
        chk_state("coll_rise_after", 8'h02, 8'h00);
        bus.signal[1] = 1'b0;
        expect_ev(cyc + LAT, 8'h00, 8'h02, 8'h00, 8'h02);
        tick(7);
        chk_state("coll_fall_after", 8'h00, 8'h00);
        bus.clr[1] = 1'b0;

        // Reset mid-debounce on channel 2 while channel 5 holds pending
        bus.mode = 16'h0400;
        bus.signal[5] = 1'b1;
        expect_ev(cyc + LAT, 8'h20, 8'h00, 8'h20, 8'h20);
        tick(8);
        chk_state("pre_reset", 8'h20, 8'h20);
        bus.signal[2] = 1'b1;
        tick(4);
        n_rst = 1'b0;
        #1;
        chk_state("mid_reset", 8'h00, 8'h00);
        chk("mid_reset_pulses", 32'({bus.pos_edge, bus.neg_edge}), 32'h0);
        tick(3);
        n_rst = 1'b1;
        expect_ev(cyc + LAT, 8'h24, 8'h00, 8'h24, 8'h20);
        tick(10);
        chk_state("post_reset", 8'h24, 8'h20);

        chk("events_left", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_debounce_detector.md
# edge_debounce_detector

Multi-channel edge detector with synchronisation and debounce, replacing the single-purpose `edgedetector` for asynchronous inputs such as buttons, external strobes and sensor lines. Each of WIDTH channels is synchronised, glitch-filtered, and edge-detected. Each channel also has a programmable edge mode and a sticky pending flag that feeds one aggregated interrupt. The block sits between the pad inputs and the register or interrupt controller.

## Interface
- WIDTH, 8: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; at least 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a new level must persist before it is accepted; at least 1, where 1 means no filtering.
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- signal  input  WIDTH  raw, possibly asynchronous channel inputs.
- mode  input  2*WIDTH  per-channel edge mode; channel i uses bits [2i+1:2i]. Encoding: 00 none, 01 rising, 10 falling, 11 both.
- clr  input  WIDTH  per-channel pending clear, level-sampled each cycle.
- filtered  output  WIDTH  debounced channel level.
- pos_edge  output  WIDTH  1-cycle pulse on a filtered 0->1 transition; independent of mode.
- neg_edge  output  WIDTH  1-cycle pulse on a filtered 1->0 transition; independent of mode.
- pending  output  WIDTH  sticky per-channel flag for mode-selected edges.
- irq  output  1  OR-reduction of pending.

## Operation
- Reset values: every synchroniser flop 0, debounce counter 0, filtered 0, pos_edge 0, neg_edge 0, pending 0, irq 0. Reset asserted mid-operation discards all in-flight state immediately.
- Synchroniser: a SYNC_STAGES-deep shift register per channel. Its last stage is sync_q.
- Debounce counter, per channel, width max(1, $clog2(DEBOUNCE_CYCLES)):
  - sync_q == filtered: counter <= 0.
  - sync_q != filtered and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync_q != filtered and counter == DEBOUNCE_CYCLES-1: filtered <= sync_q and counter <= 0.
  - Any return of sync_q to the filtered level before acceptance restarts the count. Glitches shorter than DEBOUNCE_CYCLES synchronised cycles are therefore never seen.
- Edge pulses are registered. They assert on the same clock edge where filtered updates and last exactly one cycle.
- Pending, per channel:
  - The set condition is (pos_edge next-state AND mode bit0) OR (neg_edge next-state AND mode bit1).
  - Set on the same edge as the pulse.
  - Cleared when clr is high and no set occurs on that edge. Set wins over a simultaneous clr.
  - Otherwise held.
- mode changes take effect on the next clock edge and do not alter existing pending bits. Mode 00 only blocks new sets; pulses and filtered still operate.
- irq is combinational OR of the pending register. It needs no extra stage.
- Channels are fully independent, and simultaneous events on different channels are all captured.
- After reset with an input held high, a pos_edge occurs once the normal latency has elapsed. This is intended behaviour.

## Timing
- Latency: signal stable at the new level before clock edge 1 → filtered, the edge pulse and pending are visible after edge SYNC_STAGES + DEBOUNCE_CYCLES. With the defaults that is after edge 6.
- The minimum accepted pulse width on signal is DEBOUNCE_CYCLES cycles, plus synchroniser sampling uncertainty of ±1 cycle.
- Back-to-back toggles are accepted at most once per DEBOUNCE_CYCLES cycles per channel.
- clr has a 1-cycle effect: pending falls after the edge that samples clr high.

## Structure
- Package `edge_debounce_pkg`:
  - `edge_mode_t` enum (EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11).
  - Helper constant function for the counter width.
- Sub-module `edge_debounce_chan`: a single channel containing the synchroniser, counter, filtered flop, pulse flops and pending flop.
- Top level: a generate loop over WIDTH channels plus the irq reduction.
- The `edgedetector_if` pattern is extended into `edge_debounce_if` with the same clk/n_rst naming and tester/dut modports.

## Test plan
- Reset and idle, defaults: hold signal=0 after n_rst release for 20 cycles -> all outputs 0, irq 0.
- Clean rise on channel 0 with mode=01: set signal[0]=1 before edge 1 -> filtered[0]=1, pos_edge[0] high exactly one cycle after edge 6, pending[0]=1, irq=1. Then clr[0]=1 for one cycle -> pending[0]=0 after that edge.
- Glitch rejection, DEBOUNCE_CYCLES=4: pulse signal[3] high for 3 cycles -> no filtered change, no pulses. A 5-cycle pulse -> one pos_edge and one later neg_edge.
- Mode matrix: channels 0–3 with modes 00, 01, 10 and 11, all driven with the same rise then fall:
  - pos_edge and neg_edge fire on all four channels.
  - pending sets on channel 1 after the rise, channel 2 after the fall, channel 3 after both, never on channel 0.
- Set/clear collision: hold clr[1]=1 continuously on a mode-11 channel and toggle its input -> pending[1] is high for exactly the cycle following each edge pulse.
- Reset mid-operation: assert n_rst during a debounce count at counter=2 -> all outputs 0 immediately. Release with the input high -> pos_edge after the full SYNC_STAGES+DEBOUNCE_CYCLES latency.
